instruction_fetch_unit: RTL and testbench

Front-end stage directly upstream of the IF/ID pipeline register. It owns the program counter, issues word fetches to instruction memory, and buffers returned instructions with their PC in a small queue. It presents {instruction, pc} to IF/ID through a valid/ready handshake and absorbs decode stalls and branch/jump redirects from later stages.

---
 rtl/instruction_fetch_unit_if.sv | 32 +++
 rtl/instruction_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, redirect input
// and the {instruction, pc} valid/ready stream toward IF/ID.
interface instruction_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;

    // Fetch unit side
    modport master (
        output imem_req, imem_addr,
        input  imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output out_valid, out_instruction, out_pc,
        input  out_ready
    );

    // Memory / downstream / redirect source side
    modport slave (
        input  imem_req, imem_addr,
        output imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  out_valid, out_instruction, out_pc,
        output out_ready
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, keeps at most one imem request in
// flight, queues returned words with their PC and hands them to IF/ID.
// Optional macro FETCH_BYPASS_EN: a response arriving while the queue is
// empty is presented on out_* in the same cycle.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    instruction_fetch_unit_if.master   fetch_bus
);
    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic             outstanding_q, outstanding_d;
    logic             discard_q, discard_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      instr_mem_q [QUEUE_DEPTH];
    logic [31:0]      pc_mem_q    [QUEUE_DEPTH];

    logic issue_c;
    logic rsp_take_c;
    logic bypass_pop_c;
    logic push_c;
    logic pop_c;

    // Issue only when the worst-case occupancy (queued + in flight) leaves a slot
    always_comb begin
        issue_c = 1'b0;
        if (!reset && !fetch_bus.redirect_valid
            && (!outstanding_q || fetch_bus.imem_rsp_valid)
            && ((32'(count_q) + 32'(outstanding_q)) < QUEUE_DEPTH)) begin
            issue_c = 1'b1;
        end
    end

    // A response is kept only if it belongs to a live request
    assign rsp_take_c = fetch_bus.imem_rsp_valid && outstanding_q && !discard_q
                        && !fetch_bus.redirect_valid && !reset;

    assign fetch_bus.imem_req  = issue_c;
    assign fetch_bus.imem_addr = fetch_pc_q;

`ifdef FETCH_BYPASS_EN
    logic bypass_c;
    assign bypass_c                  = rsp_take_c && (count_q == '0);
    assign bypass_pop_c              = bypass_c && fetch_bus.out_ready;
    assign fetch_bus.out_valid       = bypass_c || (count_q != '0);
    assign fetch_bus.out_instruction = bypass_c ? fetch_bus.imem_rsp_data : instr_mem_q[rd_ptr_q];
    assign fetch_bus.out_pc          = bypass_c ? req_pc_q : pc_mem_q[rd_ptr_q];
`else
    assign bypass_pop_c              = 1'b0;
    assign fetch_bus.out_valid       = (count_q != '0);
    assign fetch_bus.out_instruction = instr_mem_q[rd_ptr_q];
    assign fetch_bus.out_pc          = pc_mem_q[rd_ptr_q];
`endif

    assign push_c = rsp_take_c && !bypass_pop_c;
    assign pop_c  = (count_q != '0) && fetch_bus.out_ready;

    // Next-state: redirect flushes and retargets, otherwise issue/push/pop
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        if (fetch_bus.redirect_valid) begin
            fetch_pc_d    = {fetch_bus.redirect_pc[31:2], 2'b00};
            // A request still in flight must be swallowed when it returns
            outstanding_d = outstanding_q && !fetch_bus.imem_rsp_valid;
            discard_d     = outstanding_q && !fetch_bus.imem_rsp_valid;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
            count_d       = '0;
        end else begin
            if (issue_c) begin
                fetch_pc_d    = fetch_pc_q + 32'd4;
                req_pc_d      = fetch_pc_q;
                outstanding_d = 1'b1;
            end else if (fetch_bus.imem_rsp_valid) begin
                outstanding_d = 1'b0;
            end
            if (fetch_bus.imem_rsp_valid && discard_q) begin
                discard_d = 1'b0;
            end
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_c && !pop_c) begin
                count_d = count_q + CNT_W'(1);
            end else if (!push_c && pop_c) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            req_pc_q      <= RESET_PC;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // Queue storage; contents are meaningless while count is zero
    always_ff @(posedge clk) begin
        if (push_c) begin
            instr_mem_q[wr_ptr_q] <= fetch_bus.imem_rsp_data;
            pc_mem_q[wr_ptr_q]    <= req_pc_q;
        end
    end

    // Occupancy accounting in the issue rule makes overflow impossible
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(push_c && !pop_c && (count_q == CNT_W'(QUEUE_DEPTH))));
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus a randomized run,
// all checked against a stream-level model (expected fetch address and
// expected delivered PC, memory contents a ^ 0xA5A5_0000).
module tb_instruction_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int unsigned DEPTH  = 2;
`ifdef FETCH_BYPASS_EN
    localparam int EXP_LAT = 1;
    localparam int EXP_GAP = 1;
`else
    localparam int EXP_LAT = 2;
    localparam int EXP_GAP = 2;
`endif

    logic clk = 1'b0;
    logic reset;
    instruction_fetch_unit_if bus ();

    instruction_fetch_unit #(.RESET_PC(RST_PC), .QUEUE_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .fetch_bus (bus)
    );

    always #5 clk = ~clk;

    int          checks;
    int          failures;
    int          cyc;
    int          issues;
    int          pops;
    int          first_req;
    int          first_val;
    int          last_pop_cyc;
    int          max_gap;
    logic [31:0] exp_fetch;
    logic [31:0] exp_out;
    int          pend_due[$];
    logic [31:0] pend_addr[$];
    bit          drv_reset;
    bit          drv_redir;
    bit          redir_on_rsp;
    bit          redir_seen;
    bit          prev_reset;
    logic [31:0] drv_redir_pc;
    int unsigned lat_min;
    int unsigned lat_max;
    int unsigned ready_pct;
    bit          obs_valid;
    logic [31:0] obs_pc;
    logic [31:0] first_pop_pc;
    bit          first_pop_seen;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive inputs at negedge, observe 1ns later, advance the model
    task automatic step();
        bit rsp_v;
        @(negedge clk);
        cyc++;
        rsp_v = 1'b0;
        bus.imem_rsp_data = $urandom;
        if (pend_due.size() > 0) begin
            if ((pend_due[0] <= cyc) || drv_reset) begin
                rsp_v = 1'b1;
                bus.imem_rsp_data = mem_word(pend_addr[0]);
            end
        end
        bus.imem_rsp_valid = rsp_v;
        reset              = drv_reset;
        bus.redirect_valid = drv_redir || (redir_on_rsp && rsp_v);
        bus.redirect_pc    = drv_redir_pc;
        bus.out_ready      = ($urandom_range(99) < ready_pct);
        #1;
        obs_valid = bus.out_valid;
        obs_pc    = bus.out_pc;
        if (rsp_v) begin
            void'(pend_due.pop_front());
            void'(pend_addr.pop_front());
        end
        if (prev_reset) check32("valid_after_reset", 32'(bus.out_valid), 32'd0);
        if (drv_reset) begin
            check32("req_in_reset", 32'(bus.imem_req), 32'd0);
            pend_due.delete();
            pend_addr.delete();
            exp_fetch      = RST_PC;
            exp_out        = RST_PC;
            first_pop_seen = 1'b0;
        end else if (bus.redirect_valid) begin
            redir_seen = 1'b1;
            check32("req_in_redirect", 32'(bus.imem_req), 32'd0);
            exp_fetch      = {drv_redir_pc[31:2], 2'b00};
            exp_out        = {drv_redir_pc[31:2], 2'b00};
            first_pop_seen = 1'b0;
        end else begin
            if (bus.imem_req) begin
                check32("one_outstanding", 32'(pend_due.size()), 32'd0);
                check32("imem_addr", bus.imem_addr, exp_fetch);
                exp_fetch = exp_fetch + 32'd4;
                pend_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
                pend_addr.push_back(bus.imem_addr);
                issues++;
                if (first_req == 0) first_req = cyc;
            end
            if (bus.out_valid && (first_val == 0)) first_val = cyc;
            if (bus.out_valid && bus.out_ready) begin
                check32("out_pc", bus.out_pc, exp_out);
                check32("out_instruction", bus.out_instruction, mem_word(exp_out));
                if (!first_pop_seen) begin
                    first_pop_seen = 1'b1;
                    first_pop_pc   = bus.out_pc;
                end
                if ((last_pop_cyc != 0) && (cyc - last_pop_cyc > max_gap)) max_gap = cyc - last_pop_cyc;
                last_pop_cyc = cyc;
                exp_out      = exp_out + 32'd4;
                pops++;
            end
        end
        prev_reset = drv_reset;
    endtask

    task automatic do_reset();
        drv_reset = 1'b1;
        step();
        step();
        drv_reset    = 1'b0;
        first_req    = 0;
        first_val    = 0;
        pops         = 0;
        issues       = 0;
        last_pop_cyc = 0;
        max_gap      = 0;
    endtask

    initial begin
        int n;
        checks = 0; failures = 0; cyc = 0;
        reset = 1'b1;
        bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.out_ready = 1'b0;
        drv_redir = 1'b0; redir_on_rsp = 1'b0; redir_seen = 1'b0; prev_reset = 1'b0;
        drv_redir_pc = '0; first_pop_pc = '0; first_pop_seen = 1'b0;
        exp_fetch = RST_PC; exp_out = RST_PC;

        // Streaming from reset with a 1-cycle memory
        lat_min = 1; lat_max = 1; ready_pct = 100;
        do_reset();
        repeat (12) step();
        check32("first_latency", 32'(first_val - first_req), 32'(EXP_LAT));
        check32("first_pc", first_pop_pc, RST_PC);
        check32("max_gap", 32'(max_gap), 32'(EXP_GAP));

        // Decode stall: queue fills to DEPTH and fetching stops
        ready_pct = 0;
        do_reset();
        repeat (8) step();
        check32("stall_issues", 32'(issues), 32'(DEPTH));
        check32("stall_valid", 32'(obs_valid), 32'd1);
        check32("stall_head_pc", obs_pc, RST_PC);
        ready_pct = 100;
        repeat (8) step();
        check32("stall_release_pc", first_pop_pc, RST_PC);
        check32("stall_release_pops", 32'(pops >= 3), 32'd1);

        // Redirect while a slow request is in flight
        lat_min = 1; lat_max = 1;
        do_reset();
        repeat (6) step();
        lat_min = 3; lat_max = 3;
        n = issues;
        for (int i = 0; i < 10 && issues == n; i++) step();
        check32("c_issue_seen", 32'(issues != n), 32'd1);
        drv_redir = 1'b1; drv_redir_pc = 32'h0000_2000;
        step();
        drv_redir = 1'b0;
        lat_min = 1; lat_max = 1;
        repeat (12) step();
        check32("c_pop_seen", 32'(first_pop_seen), 32'd1);
        check32("c_first_pc", first_pop_pc, 32'h0000_2000);

        // Redirect landing on the response cycle, unaligned target
        lat_min = 2; lat_max = 2;
        do_reset();
        repeat (4) step();
        redir_seen = 1'b0; redir_on_rsp = 1'b1; drv_redir_pc = 32'h0000_3002;
        for (int i = 0; i < 10 && !redir_seen; i++) step();
        redir_on_rsp = 1'b0;
        check32("d_redirect_hit", 32'(redir_seen), 32'd1);
        repeat (12) step();
        check32("d_first_pc", first_pop_pc, 32'h0000_3000);

        // Reset mid-stream with a queued entry and a request in flight
        lat_min = 3; lat_max = 3; ready_pct = 0;
        do_reset();
        for (int i = 0; i < 20 && !(obs_valid && pend_due.size() > 0); i++) step();
        check32("e_setup", 32'(obs_valid && pend_due.size() > 0), 32'd1);
        drv_reset = 1'b1;
        step();
        drv_reset = 1'b0;
        lat_min = 1; lat_max = 1; ready_pct = 100;
        step();
        check32("e_valid_after_reset", 32'(obs_valid), 32'd0);
        repeat (10) step();
        check32("e_restart_pc", first_pop_pc, RST_PC);

        // Randomized latency, stalls, redirects (including near wrap) and resets
        lat_min = 1; lat_max = 3; ready_pct = 70;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drv_reset    = ($urandom_range(199) == 0);
            drv_redir    = ($urandom_range(24) == 0);
            drv_redir_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            step();
        end
        drv_reset = 1'b0;
        drv_redir = 1'b0;
        check32("rand_pops", 32'(pops > 500), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
